// File: rtl/alu_pkg.sv
// Shared ALUControl code constants and execution-unit state encoding.
// Imported by the ALU decoder and by the sequential execution unit.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

endpackage

// File: rtl/alu_seq_exec_mul_shift_add.sv
// Iterative shift-add multiplier datapath: one partial product per step,
// overflow above WIDTH bits discarded on every add.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;

    // Accumulator plus the current partial product: the value the next step stores.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with Start/Busy/Done handshake; single-cycle ops finish
// in one clock, MUL iterates over WIDTH clocks through mul_shift_add.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d, busy_d, done_d;
    logic [WIDTH-1:0] alu_y;
    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_product;

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (CLK),
        .rst_n   (RST),
        .load    (mul_load),
        .step    (mul_step),
        .a       (SrcA),
        .b       (SrcB),
        .last    (mul_last),
        .product (mul_product)
    );

    always_comb begin
        alu_y = '0;
        case (ALUControl)
            ALU_ADD: alu_y = SrcA + SrcB;
            ALU_SUB: alu_y = SrcA - SrcB;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_AND: alu_y = SrcA & SrcB;
            ALU_OR:  alu_y = SrcA | SrcB;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = ALUResult;
        zero_d   = Zero;
        busy_d   = Busy;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (ALUControl == ALU_MUL) begin
                        mul_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        result_d = alu_y;
                        zero_d   = (alu_y == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // Start is ignored here; the final step's sum goes straight to the output.
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ALUResult <= result_d;
            Zero      <= zero_d;
            Busy      <= busy_d;
            Done      <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed and random operations
// against an arithmetic reference model of the operation codes.
module tb_alu_seq_exec;

    localparam int unsigned W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Start = 1'b0;
    logic [2:0]   ALUControl = '0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [W-1:0] ALUResult;
    logic         Zero, Busy, Done;

    int checks = 0;
    int failures = 0;

    alu_seq_exec #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'b010: return a + b;
            3'b100: return a - b;
            3'b110: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'b000: return a & b;
            3'b001: return a | b;
            3'b101: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start = 1'b1;
        ALUControl = op;
        SrcA = a;
        SrcB = b;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        ALUControl = 3'($urandom);
        SrcA = $urandom;
        SrcB = $urandom;
    endtask

    // Called just after E0; returns edges until Done and how many of those cycles had Busy high.
    task automatic wait_done(output int cyc, output int busy_cyc, output int overlap);
        cyc = 0;
        busy_cyc = 0;
        overlap = 0;
        while (!Done && cyc < 40) begin
            if (Busy) busy_cyc++;
            @(posedge CLK);
            #1;
            cyc++;
            if (Busy && Done) overlap++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (ALUResult !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=%h", ALUResult, 32'd0); end
        checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", Zero); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_single();
        logic [2:0]  ops [9] = '{3'b010, 3'b010, 3'b100, 3'b110, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};
        logic [31:0] as  [9] = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'd1, 32'hF0F0A5A5, 32'h0F00000F, 32'h1234, 32'h55};
        logic [31:0] bs  [9] = '{32'd7, 32'd1, 32'd3, 32'd1, 32'hFFFFFFFF, 32'hFF0F5A5A, 32'h00F0F000, 32'h5678, 32'hAA};
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        for (int i = 0; i < 49; i++) begin
            if (i < 9) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = 3'($urandom_range(0, 7));
                if (op == 3'b101) op = 3'b010;
                a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            end
            exp = ref_alu(op, a, b);
            issue(op, a, b);
            checks++; if (Done !== 1'b1) begin failures++; $display("FAIL single_done op=%b got=%b exp=1", op, Done); end
            checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL single_busy op=%b got=%b exp=0", op, Busy); end
            checks++; if (ALUResult !== exp) begin failures++; $display("FAIL single_result op=%b a=%h b=%h got=%h exp=%h", op, a, b, ALUResult, exp); end
            checks++; if (Zero !== (exp == 32'd0)) begin failures++; $display("FAIL single_zero op=%b got=%b exp=%b", op, Zero, exp == 32'd0); end
            @(posedge CLK);
            #1;
            checks++; if (Done !== 1'b0) begin failures++; $display("FAIL single_done_pulse op=%b got=%b exp=0", op, Done); end
            checks++; if (ALUResult !== exp) begin failures++; $display("FAIL single_hold op=%b got=%h exp=%h", op, ALUResult, exp); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b, exp;
        int cyc, busy_cyc, overlap;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin a = 32'd12345;      b = 32'd678;        end
                1: begin a = 32'hFFFFFFFF;   b = 32'hFFFFFFFF;   end
                2: begin a = $urandom;       b = 32'd0;          end
                3: begin a = 32'h00010000;   b = 32'h00010000;   end
                default: begin a = $urandom; b = $urandom;       end
            endcase
            exp = ref_alu(3'b101, a, b);
            issue(3'b101, a, b);
            wait_done(cyc, busy_cyc, overlap);
            checks++; if (cyc != 32) begin failures++; $display("FAIL mul_latency a=%h b=%h got=%0d exp=32", a, b, cyc); end
            checks++; if (busy_cyc != 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", busy_cyc); end
            checks++; if (overlap != 0) begin failures++; $display("FAIL mul_busy_done_overlap got=%0d exp=0", overlap); end
            checks++; if (ALUResult !== exp) begin failures++; $display("FAIL mul_result a=%h b=%h got=%h exp=%h", a, b, ALUResult, exp); end
            checks++; if (Zero !== (exp == 32'd0)) begin failures++; $display("FAIL mul_zero got=%b exp=%b", Zero, exp == 32'd0); end
            @(posedge CLK);
            #1;
            checks++; if (Done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", Done); end
        end
    endtask

    task automatic test_start_during_mul();
        logic [31:0] a, b, exp, res;
        int dones;
        a = $urandom | 32'd1;
        b = $urandom | 32'd1;
        exp = ref_alu(3'b101, a, b);
        res = '0;
        dones = 0;
        issue(3'b101, a, b);
        for (int i = 0; i < 45; i++) begin
            if (i == 5) begin
                Start = 1'b1; ALUControl = 3'b010; SrcA = 32'd1; SrcB = 32'd1;
            end
            if (i == 6) Start = 1'b0;
            @(posedge CLK);
            #1;
            if (Done) begin dones++; res = ALUResult; end
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
        checks++; if (res !== exp) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", res, exp); end
        checks++; if (ALUResult !== exp) begin failures++; $display("FAIL busy_start_hold got=%h exp=%h", ALUResult, exp); end
    endtask

    task automatic test_reset_abort();
        int dones;
        issue(3'b101, 32'd1000, 32'd1000);
        repeat (10) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++; if (ALUResult !== 32'd0) begin failures++; $display("FAIL abort_result got=%h exp=%h", ALUResult, 32'd0); end
        checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL abort_zero got=%b exp=1", Zero); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", Done); end
        @(negedge CLK);
        RST = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (Done || Busy) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        issue(3'b010, 32'd2, 32'd2);
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL abort_add_done got=%b exp=1", Done); end
        checks++; if (ALUResult !== 32'd4) begin failures++; $display("FAIL abort_add_result got=%h exp=%h", ALUResult, 32'd4); end
    endtask

    task automatic test_back_to_back();
        int cyc, busy_cyc, overlap;
        issue(3'b101, 32'd3, 32'd4);
        wait_done(cyc, busy_cyc, overlap);
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL b2b_mul_done got=%b exp=1", Done); end
        checks++; if (ALUResult !== ref_alu(3'b101, 32'd3, 32'd4)) begin failures++; $display("FAIL b2b_mul_result got=%h exp=%h", ALUResult, 32'd12); end
        Start = 1'b1; ALUControl = 3'b100; SrcA = 32'd10; SrcB = 32'd1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL b2b_sub_done got=%b exp=1", Done); end
        checks++; if (ALUResult !== ref_alu(3'b100, 32'd10, 32'd1)) begin failures++; $display("FAIL b2b_sub_result got=%h exp=%h", ALUResult, 32'd9); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL b2b_sub_busy got=%b exp=0", Busy); end
        @(posedge CLK);
        #1;
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL b2b_done_end got=%b exp=0", Done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_start_during_mul();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
